// File: rtl/elevator_scheduler.sv
// Single-car elevator scheduler: latches floor calls, keeps travelling in one
// direction while calls remain ahead of the car, and services a door timer.
module elevator_scheduler #(
  parameter int NUM_FLOORS  = 8,
  parameter int FLOOR_W     = 3,
  parameter int MOVE_CYCLES = 3,
  parameter int DOOR_CYCLES = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_FLOORS-1:0] REQ,
  input  logic                  EMERG_STOP,
  output logic [FLOOR_W-1:0]    FLOOR,
  output logic                  DIR,
  output logic                  MOVING,
  output logic                  DOOR_OPEN,
  output logic [NUM_FLOORS-1:0] PENDING,
  output logic [1:0]            STATE
);

  localparam int MW =
    (MOVE_CYCLES > 1) ? $clog2(MOVE_CYCLES) : 1;
  localparam int DW =
    (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [MW-1:0] MLAST = MW'(MOVE_CYCLES - 1);
  localparam logic [DW-1:0] DLAST = DW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MOVE = 2'd1,
    S_DOOR = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [FLOOR_W-1:0]      floor_q, floor_d;
  logic                    dir_q, dir_d;
  logic [NUM_FLOORS-1:0]   pend_q, pend_d;
  logic [MW-1:0]           mcnt_q, mcnt_d;
  logic [DW-1:0]           dcnt_q, dcnt_d;

  logic [FLOOR_W-1:0]      step_floor;
  logic [NUM_FLOORS-1:0]   here_m;
  logic [NUM_FLOORS-1:0]   step_m;
  logic [NUM_FLOORS-1:0]   clr_m;
  logic [NUM_FLOORS-1:0]   req_eff;
  logic                    door_kick;

  // Is any latched call strictly past floor f in the given direction?
  function automatic logic beyond(
    input logic [NUM_FLOORS-1:0] p,
    input logic [FLOOR_W-1:0]    f,
    input logic                  up
  );
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (p[i] && (up ? (i > int'(f)) : (i < int'(f))))
        r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [NUM_FLOORS-1:0] onehot(
    input logic [FLOOR_W-1:0] f
  );
    logic [NUM_FLOORS-1:0] m;
    m    = '0;
    m[f] = 1'b1;
    return m;
  endfunction

  assign step_floor = dir_q ? floor_q + FLOOR_W'(1)
                            : floor_q - FLOOR_W'(1);
  assign here_m     = onehot(floor_q);
  assign step_m     = onehot(step_floor);

  // A call for the floor whose door is open re-arms the door timer
  // instead of becoming a pending call.
  assign door_kick = (state_q == S_DOOR) && REQ[floor_q];
  assign req_eff   = (state_q == S_DOOR) ? (REQ & ~here_m) : REQ;

  // Next-state, counters and call clearing
  always_comb begin
    state_d = state_q;
    floor_d = floor_q;
    dir_d   = dir_q;
    mcnt_d  = mcnt_q;
    dcnt_d  = dcnt_q;
    clr_m   = '0;
    if (EMERG_STOP) begin
      state_d = S_HALT;
      mcnt_d  = '0;
      dcnt_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pend_q[floor_q]) begin
            state_d = S_DOOR;
            clr_m   = here_m;
            dcnt_d  = '0;
          end else if (|pend_q) begin
            if (!beyond(pend_q, floor_q, dir_q))
              dir_d = ~dir_q;
            state_d = S_MOVE;
            mcnt_d  = '0;
          end
        end
        S_MOVE: begin
          if (mcnt_q == MLAST) begin
            floor_d = step_floor;
            mcnt_d  = '0;
            if (pend_q[step_floor]) begin
              state_d = S_DOOR;
              clr_m   = step_m;
              dcnt_d  = '0;
            end else if (!beyond(pend_q, step_floor, dir_q)) begin
              state_d = S_IDLE;
            end
          end else begin
            mcnt_d = mcnt_q + MW'(1);
          end
        end
        S_DOOR: begin
          if (door_kick) begin
            dcnt_d = '0;
          end else if (dcnt_q == DLAST) begin
            state_d = S_IDLE;
            dcnt_d  = '0;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end
        S_HALT: begin
          state_d = S_IDLE;
        end
      endcase
    end
    pend_d = (pend_q | req_eff) & ~clr_m;
  end

  // State registers with asynchronous reset
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= S_IDLE;
      floor_q <= '0;
      dir_q   <= 1'b1;
      pend_q  <= '0;
      mcnt_q  <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      mcnt_q  <= mcnt_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign FLOOR     = floor_q;
  assign DIR       = dir_q;
  assign PENDING   = pend_q;
  assign STATE     = state_q;
  assign MOVING    = (state_q == S_MOVE);
  assign DOOR_OPEN = (state_q == S_DOOR);

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler: every cycle is compared against a
// trip-level model, plus literal expectations for the key scenarios.
module tb_elevator_scheduler;

  localparam int NF = 8;
  localparam int MC = 3;
  localparam int DC = 4;

  logic          CLK;
  logic          RESET;
  logic [NF-1:0] REQ;
  logic          EMERG_STOP;
  logic [2:0]    FLOOR;
  logic          DIR;
  logic          MOVING;
  logic          DOOR_OPEN;
  logic [NF-1:0] PENDING;
  logic [1:0]    STATE;

  elevator_scheduler #(
    .NUM_FLOORS (NF),
    .FLOOR_W    (3),
    .MOVE_CYCLES(MC),
    .DOOR_CYCLES(DC)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .REQ       (REQ),
    .EMERG_STOP(EMERG_STOP),
    .FLOOR     (FLOOR),
    .DIR       (DIR),
    .MOVING    (MOVING),
    .DOOR_OPEN (DOOR_OPEN),
    .PENDING   (PENDING),
    .STATE     (STATE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Model: mode 0 idle, 1 travelling, 2 door open, 3 halted.
  // m_left = cycles still to go in the current leg or door opening.
  int          m_mode;
  int          m_floor;
  bit          m_up;
  bit [NF-1:0] m_pend;
  int          m_left;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic bit ahead(input bit [NF-1:0] p, input int f,
                               input bit up);
    bit r;
    r = 1'b0;
    for (int i = 0; i < NF; i++)
      if (p[i] && (up ? i > f : i < f)) r = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_floor = 0;
    m_up    = 1'b1;
    m_pend  = '0;
    m_left  = 0;
  endtask

  task automatic model_step(input bit [NF-1:0] r, input bit e);
    bit [NF-1:0] np;
    np = m_pend | r;
    if (m_mode == 2) np[m_floor] = m_pend[m_floor];
    if (e) begin
      m_mode = 3;
      m_pend = np;
      return;
    end
    case (m_mode)
      0: if (m_pend != '0) begin
        if (m_pend[m_floor]) begin
          m_mode = 2;
          m_left = DC;
          np[m_floor] = 1'b0;
        end else begin
          if (!ahead(m_pend, m_floor, m_up)) m_up = !m_up;
          m_mode = 1;
          m_left = MC;
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          m_floor = m_up ? m_floor + 1 : m_floor - 1;
          if (m_pend[m_floor]) begin
            m_mode = 2;
            m_left = DC;
            np[m_floor] = 1'b0;
          end else if (ahead(m_pend, m_floor, m_up)) begin
            m_left = MC;
          end else begin
            m_mode = 0;
          end
        end
      end
      2: begin
        if (r[m_floor]) m_left = DC;
        else begin
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
      end
      default: m_mode = 0;
    endcase
    m_pend = np;
  endtask

  task automatic compare_all();
    check("state", int'(STATE), m_mode);
    check("floor", int'(FLOOR), m_floor);
    check("dir", int'(DIR), int'(m_up));
    check("pending", int'(PENDING), int'(m_pend));
    check("moving", int'(MOVING), int'(m_mode == 1));
    check("door_open", int'(DOOR_OPEN), int'(m_mode == 2));
    check("excl", int'(MOVING & DOOR_OPEN), 0);
  endtask

  // One clock: drive inputs, step the model on the edge, compare after.
  task automatic tick(input bit [NF-1:0] r, input bit e);
    REQ        = r;
    EMERG_STOP = e;
    @(posedge CLK);
    if (RESET) model_reset();
    else model_step(r, e);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic wait_state(input int st, input string nm);
    for (int k = 0; k < 300; k++) begin
      if (int'(STATE) == st) break;
      tick('0, 1'b0);
    end
    check(nm, int'(STATE), st);
  endtask

  initial begin
    int n;
    RESET      = 1'b1;
    REQ        = '0;
    EMERG_STOP = 1'b0;
    model_reset();
    @(negedge CLK);
    check("rst_state", int'(STATE), 0);
    check("rst_floor", int'(FLOOR), 0);
    check("rst_dir", int'(DIR), 1);
    check("rst_pend", int'(PENDING), 0);
    RESET = 1'b0;
    tick('0, 1'b0);
    check("idle_stay", int'(STATE), 0);

    // Trip 0 -> 5
    tick(8'h20, 1'b0);
    check("t5_pend", int'(PENDING), 'h20);
    check("t5_idle", int'(STATE), 0);
    tick('0, 1'b0);
    check("t5_move", int'(STATE), 1);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      tick('0, 1'b0);
      if (FLOOR == 3'd5) begin
        n = k;
        break;
      end
    end
    check("t5_cycles", n, 15);
    check("t5_door", int'(DOOR_OPEN), 1);
    check("t5_clr", int'(PENDING), 0);
    n = 1;
    for (int k = 0; k < 20 && DOOR_OPEN; k++) begin
      tick('0, 1'b0);
      if (DOOR_OPEN) n++;
    end
    check("t5_doorlen", n, 4);
    check("t5_end", int'(STATE), 0);

    // Top floor, then reverse to floor 2
    tick(8'h80, 1'b0);
    wait_state(1, "t7_move");
    wait_state(2, "t7_door");
    check("t7_floor", int'(FLOOR), 7);
    wait_state(0, "t7_idle");
    tick(8'h04, 1'b0);
    tick('0, 1'b0);
    check("t2_move", int'(STATE), 1);
    check("t2_dir", int'(DIR), 0);
    wait_state(2, "t2_door");
    check("t2_floor", int'(FLOOR), 2);
    wait_state(0, "t2_idle");

    // Up to 3, then calls at 1 and 6
    tick(8'h08, 1'b0);
    wait_state(1, "t3_move");
    check("t3_dir", int'(DIR), 1);
    wait_state(2, "t3_door");
    wait_state(0, "t3_idle");
    tick(8'h42, 1'b0);
    check("two_pend", int'(PENDING), 'h42);
    tick('0, 1'b0);
    check("two_dir", int'(DIR), 1);
    wait_state(2, "two_door6");
    check("two_f6", int'(FLOOR), 6);
    wait_state(1, "two_rev");
    check("two_rdir", int'(DIR), 0);
    wait_state(2, "two_door1");
    check("two_f1", int'(FLOOR), 1);
    wait_state(0, "two_idle");

    // Door restart at floor 4
    tick(8'h10, 1'b0);
    wait_state(1, "d4_move");
    wait_state(2, "d4_door");
    check("d4_floor", int'(FLOOR), 4);
    tick('0, 1'b0);
    tick('0, 1'b0);
    tick(8'h10, 1'b0);
    check("d4_pend", int'(PENDING), 0);
    n = 1;
    for (int k = 0; k < 20 && DOOR_OPEN; k++) begin
      tick('0, 1'b0);
      if (DOOR_OPEN) n++;
    end
    check("d4_extend", n, 4);

    // Emergency stop mid-leg between floors 2 and 3
    tick(8'h04, 1'b0);
    wait_state(2, "e_door2");
    check("e_f2", int'(FLOOR), 2);
    wait_state(0, "e_idle2");
    tick(8'h08, 1'b0);
    tick('0, 1'b0);
    check("e_move", int'(STATE), 1);
    tick('0, 1'b0);
    tick('0, 1'b1);
    check("e_halt", int'(STATE), 3);
    check("e_hfloor", int'(FLOOR), 2);
    check("e_hmov", int'(MOVING), 0);
    tick(8'h01, 1'b1);
    check("e_hpend", int'(PENDING), 'h09);
    tick('0, 1'b0);
    check("e_rel", int'(STATE), 0);
    check("e_rfloor", int'(FLOOR), 2);
    tick('0, 1'b0);
    check("e_resume", int'(STATE), 1);
    n = 0;
    for (int k = 1; k <= 20; k++) begin
      tick('0, 1'b0);
      if (FLOOR == 3'd3) begin
        n = k;
        break;
      end
    end
    check("e_leg", n, 3);
    check("e_door3", int'(DOOR_OPEN), 1);

    // Asynchronous reset in the middle of the door cycle
    tick('0, 1'b0);
    #2;
    RESET = 1'b1;
    #1;
    check("ar_state", int'(STATE), 0);
    check("ar_floor", int'(FLOOR), 0);
    check("ar_dir", int'(DIR), 1);
    check("ar_pend", int'(PENDING), 0);
    check("ar_door", int'(DOOR_OPEN), 0);
    model_reset();
    tick(8'h01, 1'b0);
    check("ar_ignore", int'(PENDING), 0);
    RESET = 1'b0;
    tick('0, 1'b0);
    check("ar_idle", int'(STATE), 0);
    tick(8'h02, 1'b0);
    wait_state(2, "ar_door1");
    check("ar_f1", int'(FLOOR), 1);
    wait_state(0, "ar_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
